atm_pin_auth: RTL and testbench

- Card-and-PIN authentication front end that sits directly upstream of the ATM transaction controller.
- Collects keypad digits serially and converts them to a 14-bit binary PIN, then compares the result against the stored card PIN.
- Counts failed attempts and retains the card after too many failures.
- A successful check produces a one-cycle auth_ok pulse with the PIN, which releases the controller from its PIN stage to its home menu.

---
 rtl/atm_pin_auth.sv | 186 ++++++++++++++++++
 tb/tb_atm_pin_auth.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_pin_auth.sv
// Card-and-PIN authentication front end: serial BCD keypad entry, PIN compare, retry limit, card retention.
// Optional inactivity timeout in the entry stage is built when PIN_TIMEOUT_EN is defined.
module atm_pin_auth #(
    parameter int          PIN_DIGITS     = 4,
    parameter int          MAX_TRIES      = 3,
    parameter logic [13:0] STORED_PIN     = 14'd8030,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        card_inserted,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        key_enter,
    input  logic        key_clear,
    input  logic        key_cancel,
    output logic [13:0] pin_value,
    output logic [2:0]  digit_count,
    output logic [1:0]  tries_left,
    output logic        auth_ok,
    output logic        auth_fail,
    output logic        card_retained,
    output logic        eject_req,
    output logic        busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_GRANTED = 3'd3;
    localparam logic [2:0] S_SESSION = 3'd4;
    localparam logic [2:0] S_FAIL    = 3'd5;
    localparam logic [2:0] S_LOCKED  = 3'd6;
    localparam logic [2:0] S_EJECT   = 3'd7;

    localparam logic [2:0] DIGITS_FULL = 3'(PIN_DIGITS);
    localparam logic [1:0] TRIES_INIT  = 2'(MAX_TRIES);

    logic [2:0]  state_reg, state_next;
    logic [13:0] pin_reg, pin_next;
    logic [2:0]  count_reg, count_next;
    logic [1:0]  tries_reg, tries_next;
    logic        card_prev_reg;
    logic        auth_ok_reg, auth_fail_reg, retained_reg, eject_reg, busy_reg;

    logic        accepted;
    logic        timeout_hit;
    logic        digit_ok;
    logic        card_rise;
    logic        card_fall;
    logic [13:0] pin_shift;
    logic [1:0]  tries_dec;

    assign digit_ok  = key_valid && (key_digit <= 4'd9) && (count_reg < DIGITS_FULL);
    assign card_rise = card_inserted && !card_prev_reg;
    assign card_fall = !card_inserted && card_prev_reg;
    // pin*10 + digit as shift-and-add; 9999 is the largest reachable value and fits in 14 bits
    assign pin_shift = (pin_reg << 3) + (pin_reg << 1) + {10'd0, key_digit};
    assign tries_dec = (tries_reg == 2'd0) ? 2'd0 : tries_reg - 2'd1;

`ifdef PIN_TIMEOUT_EN
    logic [15:0] idle_reg, idle_next;

    assign timeout_hit = (idle_reg == 16'(TIMEOUT_CYCLES - 1));
    assign idle_next   = (state_reg == S_COLLECT && state_next == S_COLLECT && !accepted)
                         ? idle_reg + 16'd1 : 16'd0;

    always_ff @(posedge clk) begin
        if (reset) idle_reg <= 16'd0;
        else       idle_reg <= idle_next;
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_next = state_reg;
        pin_next   = pin_reg;
        count_next = count_reg;
        tries_next = tries_reg;
        accepted   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (card_rise) begin
                    state_next = S_COLLECT;
                    pin_next   = 14'd0;
                    count_next = 3'd0;
                    tries_next = TRIES_INIT;
                end
            end
            S_COLLECT: begin
                // Only the highest-priority strobe acts, even if it is itself ignored
                if (key_cancel || card_fall) begin
                    state_next = S_EJECT;
                    pin_next   = 14'd0;
                    count_next = 3'd0;
                end else if (key_clear) begin
                    pin_next   = 14'd0;
                    count_next = 3'd0;
                    accepted   = 1'b1;
                end else if (key_enter) begin
                    if (count_reg == DIGITS_FULL) begin
                        state_next = S_CHECK;
                        accepted   = 1'b1;
                    end
                end else if (digit_ok) begin
                    pin_next   = pin_shift;
                    count_next = count_reg + 3'd1;
                    accepted   = 1'b1;
                end
                if (state_next == S_COLLECT && !accepted && timeout_hit) begin
                    state_next = S_EJECT;
                    pin_next   = 14'd0;
                    count_next = 3'd0;
                end
            end
            S_CHECK: begin
                if (pin_reg == STORED_PIN) begin
                    state_next = S_GRANTED;
                end else begin
                    tries_next = tries_dec;
                    if (tries_dec == 2'd0) begin
                        state_next = S_LOCKED;
                    end else begin
                        state_next = S_FAIL;
                        pin_next   = 14'd0;
                        count_next = 3'd0;
                    end
                end
            end
            S_GRANTED: state_next = S_SESSION;
            S_SESSION: begin
                if (!card_inserted || key_cancel) begin
                    state_next = S_EJECT;
                    pin_next   = 14'd0;
                    count_next = 3'd0;
                end
            end
            S_FAIL:   state_next = S_COLLECT;
            S_LOCKED: state_next = S_LOCKED;
            S_EJECT:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Flags are decoded from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            pin_reg       <= 14'd0;
            count_reg     <= 3'd0;
            tries_reg     <= TRIES_INIT;
            card_prev_reg <= 1'b0;
            auth_ok_reg   <= 1'b0;
            auth_fail_reg <= 1'b0;
            retained_reg  <= 1'b0;
            eject_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pin_reg       <= pin_next;
            count_reg     <= count_next;
            tries_reg     <= tries_next;
            card_prev_reg <= card_inserted;
            auth_ok_reg   <= (state_next == S_GRANTED);
            auth_fail_reg <= (state_next == S_FAIL) ||
                             (state_next == S_LOCKED && state_reg != S_LOCKED);
            retained_reg  <= (state_next == S_LOCKED);
            eject_reg     <= (state_next == S_EJECT);
            busy_reg      <= (state_next != S_IDLE);
        end
    end

    assign pin_value     = pin_reg;
    assign digit_count   = count_reg;
    assign tries_left    = tries_reg;
    assign auth_ok       = auth_ok_reg;
    assign auth_fail     = auth_fail_reg;
    assign card_retained = retained_reg;
    assign eject_req     = eject_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_atm_pin_auth.sv
// Self-checking bench for atm_pin_auth: vector table, directed corner sequences, and random
// stimulus compared against a digit-queue reference model.
module tb_atm_pin_auth;

    localparam int PD     = 4;
    localparam int MT     = 3;
    localparam int TO     = 20;
    localparam int STORED = 8030;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        card_inserted = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'd0;
    logic        key_enter = 1'b0;
    logic        key_clear = 1'b0;
    logic        key_cancel = 1'b0;
    logic [13:0] pin_value;
    logic [2:0]  digit_count;
    logic [1:0]  tries_left;
    logic        auth_ok, auth_fail, card_retained, eject_req, busy;

    atm_pin_auth #(
        .PIN_DIGITS(PD), .MAX_TRIES(MT), .STORED_PIN(14'd8030), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .card_inserted(card_inserted),
        .key_valid(key_valid), .key_digit(key_digit), .key_enter(key_enter),
        .key_clear(key_clear), .key_cancel(key_cancel),
        .pin_value(pin_value), .digit_count(digit_count), .tries_left(tries_left),
        .auth_ok(auth_ok), .auth_fail(auth_fail), .card_retained(card_retained),
        .eject_req(eject_req), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic cmp(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the entered PIN is a queue of digits, the session a coarse phase
    typedef enum {M_IDLE, M_ENTRY, M_VERIFY, M_OK, M_INUSE, M_BAD, M_SWALLOWED, M_RETURN} phase_t;
    phase_t ph;
    int     dq[$];
    int     m_tries;
    bit     m_card_was;
    int     m_idle;
    bit     m_fresh;

    function automatic int m_pin();
        int p = 0;
        foreach (dq[i]) p = p * 10 + dq[i];
        return p;
    endfunction

    task automatic m_reset();
        ph = M_IDLE;
        dq.delete();
        m_tries = MT;
        m_card_was = 1'b0;
        m_idle = 0;
        m_fresh = 1'b0;
    endtask

    task automatic m_step(input bit card, input bit v, input int d, input bit e, input bit c, input bit x);
        bit act;
        act = 1'b0;
        m_fresh = 1'b0;
        case (ph)
            M_IDLE: if (card && !m_card_was) begin
                ph = M_ENTRY; dq.delete(); m_tries = MT;
            end
            M_ENTRY: begin
                if (x || (m_card_was && !card)) begin
                    ph = M_RETURN; dq.delete();
                end else if (c) begin
                    dq.delete(); act = 1'b1;
                end else if (e) begin
                    if (dq.size() == PD) begin ph = M_VERIFY; act = 1'b1; end
                end else if (v && d < 10 && dq.size() < PD) begin
                    dq.push_back(d); act = 1'b1;
                end
                if (ph == M_ENTRY) begin
                    if (act) m_idle = 0;
                    else begin
`ifdef PIN_TIMEOUT_EN
                        if (m_idle == TO - 1) begin ph = M_RETURN; dq.delete(); end
                        else m_idle++;
`endif
                    end
                end
            end
            M_VERIFY: begin
                if (m_pin() == STORED) ph = M_OK;
                else begin
                    if (m_tries > 0) m_tries--;
                    if (m_tries == 0) begin ph = M_SWALLOWED; m_fresh = 1'b1; end
                    else begin ph = M_BAD; dq.delete(); end
                end
            end
            M_OK:    ph = M_INUSE;
            M_INUSE: if (!card || x) begin ph = M_RETURN; dq.delete(); end
            M_BAD:   ph = M_ENTRY;
            M_SWALLOWED: ph = M_SWALLOWED;
            M_RETURN: ph = M_IDLE;
            default: ph = M_IDLE;
        endcase
        if (ph != M_ENTRY) m_idle = 0;
        m_card_was = card;
    endtask

    task automatic check_model(input string tag);
        cmp({tag, " pin_value"}, int'(pin_value), m_pin());
        cmp({tag, " digit_count"}, int'(digit_count), dq.size());
        cmp({tag, " tries_left"}, int'(tries_left), m_tries);
        cmp({tag, " auth_ok"}, int'(auth_ok), int'(ph == M_OK));
        cmp({tag, " auth_fail"}, int'(auth_fail), int'(ph == M_BAD || m_fresh));
        cmp({tag, " card_retained"}, int'(card_retained), int'(ph == M_SWALLOWED));
        cmp({tag, " eject_req"}, int'(eject_req), int'(ph == M_RETURN));
        cmp({tag, " busy"}, int'(busy), int'(ph != M_IDLE));
    endtask

    task automatic drive(input bit card, input bit v, input int d, input bit e, input bit c, input bit x);
        card_inserted = card;
        key_valid     = v;
        key_digit     = 4'(d);
        key_enter     = e;
        key_clear     = c;
        key_cancel    = x;
        m_step(card, v, d, e, c, x);
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        key_enter  = 1'b0;
        key_clear  = 1'b0;
        key_cancel = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        card_inserted = 1'b0;
        key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; key_cancel = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic enter_pin(input int d0, input int d1, input int d2, input int d3, input string tag);
        drive(1, 1, d0, 0, 0, 0); check_model(tag);
        drive(1, 1, d1, 0, 0, 0); check_model(tag);
        drive(1, 1, d2, 0, 0, 0); check_model(tag);
        drive(1, 1, d3, 0, 0, 0); check_model(tag);
        drive(1, 0, 0, 1, 0, 0);  check_model(tag);
    endtask

    typedef struct {
        bit card; bit v; int d; bit e; bit c; bit x;
        int pin; int cnt; int tries; bit ok; bit fail; bit eject; bit busy;
    } vec_t;

    vec_t tbl[21];

    initial begin
        int  eject_at;
        bit  card_lvl;
        int  tgt[4];

        tbl[0]  = '{1,0,0,0,0,0,    0,0,3, 0,0,0,1};
        tbl[1]  = '{1,1,8,0,0,0,    8,1,3, 0,0,0,1};
        tbl[2]  = '{1,1,0,0,0,0,   80,2,3, 0,0,0,1};
        tbl[3]  = '{1,1,10,0,0,0,  80,2,3, 0,0,0,1};
        tbl[4]  = '{1,0,0,1,0,0,   80,2,3, 0,0,0,1};
        tbl[5]  = '{1,1,3,0,0,0,  803,3,3, 0,0,0,1};
        tbl[6]  = '{1,0,0,1,0,0,  803,3,3, 0,0,0,1};
        tbl[7]  = '{1,1,0,0,0,0, 8030,4,3, 0,0,0,1};
        tbl[8]  = '{1,1,7,0,0,0, 8030,4,3, 0,0,0,1};
        tbl[9]  = '{1,0,0,1,0,0, 8030,4,3, 0,0,0,1};
        tbl[10] = '{1,0,0,0,0,0, 8030,4,3, 1,0,0,1};
        tbl[11] = '{1,0,0,0,0,0, 8030,4,3, 0,0,0,1};
        tbl[12] = '{0,0,0,0,0,0,    0,0,3, 0,0,1,1};
        tbl[13] = '{0,0,0,0,0,0,    0,0,3, 0,0,0,0};
        tbl[14] = '{1,0,0,0,0,0,    0,0,3, 0,0,0,1};
        tbl[15] = '{1,1,9,0,0,0,    9,1,3, 0,0,0,1};
        tbl[16] = '{1,1,9,0,0,0,   99,2,3, 0,0,0,1};
        tbl[17] = '{1,0,0,0,1,0,    0,0,3, 0,0,0,1};
        tbl[18] = '{1,1,1,0,0,0,    1,1,3, 0,0,0,1};
        tbl[19] = '{1,1,5,1,0,1,    0,0,3, 0,0,1,1};
        tbl[20] = '{1,0,0,0,0,0,    0,0,3, 0,0,0,0};
        tgt = '{8, 0, 3, 0};

        // Reset state
        do_reset();
        cmp("reset pin_value", int'(pin_value), 0);
        cmp("reset digit_count", int'(digit_count), 0);
        cmp("reset tries_left", int'(tries_left), MT);
        cmp("reset busy", int'(busy), 0);
        cmp("reset card_retained", int'(card_retained), 0);
        cmp("reset pulses", int'({auth_ok, auth_fail, eject_req}), 0);

        // Vector table: correct PIN with limits, then simultaneous strobes
        foreach (tbl[i]) begin
            drive(tbl[i].card, tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].c, tbl[i].x);
            cmp($sformatf("vec%0d pin_value", i), int'(pin_value), tbl[i].pin);
            cmp($sformatf("vec%0d digit_count", i), int'(digit_count), tbl[i].cnt);
            cmp($sformatf("vec%0d tries_left", i), int'(tries_left), tbl[i].tries);
            cmp($sformatf("vec%0d auth_ok", i), int'(auth_ok), int'(tbl[i].ok));
            cmp($sformatf("vec%0d auth_fail", i), int'(auth_fail), int'(tbl[i].fail));
            cmp($sformatf("vec%0d eject_req", i), int'(eject_req), int'(tbl[i].eject));
            cmp($sformatf("vec%0d busy", i), int'(busy), int'(tbl[i].busy));
            $display("vec%0d: pin=%0d cnt=%0d tries=%0d ok=%0d fail=%0d ej=%0d busy=%0d",
                     i, pin_value, digit_count, tries_left, auth_ok, auth_fail, eject_req, busy);
        end

        // Lockout after three wrong entries, then correct PIN ignored
        do_reset();
        drive(1, 0, 0, 0, 0, 0); check_model("lock insert");
        for (int k = 1; k <= 3; k++) begin
            enter_pin(1, 2, 3, 4, "lock entry");
            drive(1, 0, 0, 0, 0, 0);
            check_model("lock result");
            cmp($sformatf("lock%0d auth_fail", k), int'(auth_fail), 1);
            cmp($sformatf("lock%0d tries_left", k), int'(tries_left), 3 - k);
            if (k < 3) begin
                drive(1, 0, 0, 0, 0, 0); check_model("lock back");
            end
            $display("lockout attempt %0d: tries=%0d retained=%0d", k, tries_left, card_retained);
        end
        cmp("lock card_retained", int'(card_retained), 1);
        enter_pin(8, 0, 3, 0, "locked entry");
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            check_model("locked idle");
            cmp("locked auth_ok", int'(auth_ok), 0);
        end
        cmp("locked retained", int'(card_retained), 1);
        cmp("locked auth_fail", int'(auth_fail), 0);

        // Reset mid-entry, then re-insert
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 8, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        do_reset();
        cmp("midreset pin_value", int'(pin_value), 0);
        cmp("midreset digit_count", int'(digit_count), 0);
        cmp("midreset busy", int'(busy), 0);
        drive(1, 0, 0, 0, 0, 0);
        cmp("reinsert tries_left", int'(tries_left), 3);
        cmp("reinsert busy", int'(busy), 1);
        $display("mid-entry reset: pin=%0d tries=%0d busy=%0d", pin_value, tries_left, busy);

        // Inactivity: one digit then 100 idle cycles
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 5, 0, 0, 0);
        eject_at = -1;
        for (int i = 1; i <= 100; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            check_model("idle");
            if (eject_req && eject_at < 0) begin
                eject_at = i;
                cmp("timeout tries_left", int'(tries_left), 3);
            end
        end
`ifdef PIN_TIMEOUT_EN
        cmp("timeout eject cycle", eject_at, TO);
`else
        cmp("no-timeout eject", eject_at, -1);
        cmp("no-timeout digit_count", int'(digit_count), 1);
`endif
        $display("idle test: eject at cycle %0d", eject_at);

        // Random stimulus against the reference model
        do_reset();
        card_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int d;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                card_lvl = 1'b0;
                check_model("rnd reset");
            end
            if ($urandom_range(0, 47) == 0) card_lvl = ~card_lvl;
            if ($urandom_range(0, 1) == 0) d = tgt[(dq.size() < 4) ? dq.size() : 0];
            else d = int'($urandom_range(0, 15));
            drive(card_lvl, $urandom_range(0, 2) == 0, d, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
            check_model($sformatf("rnd%0d", i));
        end
        $display("random phase done: %0d cycles", 3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
